// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and types for the register file / scoreboard slice.
// Holds data width, register count, x0 index and the register index type.
package regfile_scoreboard_pkg;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int CNT_W = 2;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// One per-register in-flight counter: saturating up/down with clear.
// Ports: clk, rst_n, inc_i, dec_i, clr_i -> cnt_o, busy_o, undf_o.
module sb_counter
  import regfile_scoreboard_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         busy_o,
  output logic         undf_o
);

  localparam logic [W-1:0] MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      clr_i:
        cnt_d = '0;
      inc_i && !dec_i && cnt_q != MAX:
        cnt_d = cnt_q + 1'b1;
      dec_i && !inc_i && cnt_q != '0:
        cnt_d = cnt_q - 1'b1;
      default:
        cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign busy_o = cnt_q != '0;
  // a retire arriving with nothing outstanding is a bookkeeping error
  assign undf_o = dec_i && !clr_i && cnt_q == '0;

endmodule

// File: rtl/regfile_scoreboard.sv
// 32x32 register file with per-register in-flight scoreboard and RAW stall.
// Ports: WB_* commit, ID_* reads/issue/flush, ID_stall, SB_err. Macro: REGFILE_WB_BYPASS_EN.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XW = XLEN,
  parameter int NR = NREG,
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          WB_wr_en,
  input  reg_idx_t      WB_rd_sel,
  input  logic [XW-1:0] WB_rd_val,
  input  reg_idx_t      ID_rs1_sel,
  input  reg_idx_t      ID_rs2_sel,
  input  logic          ID_rs1_used,
  input  logic          ID_rs2_used,
  input  logic          ID_issue_en,
  input  reg_idx_t      ID_issue_rd,
  input  logic          ID_flush,
  output logic [XW-1:0] ID_rs1_val,
  output logic [XW-1:0] ID_rs2_val,
  output logic          ID_stall,
  output logic          SB_err
);

  localparam logic [CW-1:0] CMAX = '1;

  logic [XW-1:0] rf_q [NR];
  logic          sb_err_q;
  logic          sb_err_d;

  logic [NR-1:0][CW-1:0] cnt;
  logic [NR-1:0]         busy;
  logic [NR-1:0]         undf;

  logic wb_ok;
  logic iss_ok;
  logic busy1;
  logic busy2;
  logic sat;

  assign wb_ok = WB_wr_en && WB_rd_sel != REG_ZERO;

  // issue is only counted when it actually leaves ID
  assign iss_ok = ID_issue_en && !ID_stall &&
                  !ID_flush && ID_issue_rd != REG_ZERO;

  assign cnt[0]  = '0;
  assign busy[0] = 1'b0;
  assign undf[0] = 1'b0;

  for (genvar i = 1; i < NR; i++) begin : g_cnt
    sb_counter #(.W(CW)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_i  (iss_ok && ID_issue_rd == 5'(i)),
      .dec_i  (wb_ok && !ID_flush &&
               WB_rd_sel == 5'(i)),
      .clr_i  (ID_flush),
      .cnt_o  (cnt[i]),
      .busy_o (busy[i]),
      .undf_o (undf[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) rf_q[i] <= '0;
    end else if (wb_ok) begin
      rf_q[WB_rd_sel] <= WB_rd_val;
    end
  end

  assign sb_err_d = sb_err_q || (|undf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_err_q <= 1'b0;
    else        sb_err_q <= sb_err_d;
  end

  assign SB_err = sb_err_q;

`ifdef REGFILE_WB_BYPASS_EN
  logic hit1;
  logic hit2;

  assign hit1 = wb_ok && WB_rd_sel == ID_rs1_sel;
  assign hit2 = wb_ok && WB_rd_sel == ID_rs2_sel;

  // the retiring write is the last one outstanding: forward it, no stall
  always_comb begin
    busy1 = busy[ID_rs1_sel];
    busy2 = busy[ID_rs2_sel];
    if (hit1 && cnt[ID_rs1_sel] == CW'(1)) busy1 = 1'b0;
    if (hit2 && cnt[ID_rs2_sel] == CW'(1)) busy2 = 1'b0;
  end

  always_comb begin
    ID_rs1_val = rf_q[ID_rs1_sel];
    ID_rs2_val = rf_q[ID_rs2_sel];
    if (hit1) ID_rs1_val = WB_rd_val;
    if (hit2) ID_rs2_val = WB_rd_val;
    if (ID_rs1_sel == REG_ZERO) ID_rs1_val = '0;
    if (ID_rs2_sel == REG_ZERO) ID_rs2_val = '0;
  end
`else
  assign busy1 = busy[ID_rs1_sel];
  assign busy2 = busy[ID_rs2_sel];

  always_comb begin
    ID_rs1_val = rf_q[ID_rs1_sel];
    ID_rs2_val = rf_q[ID_rs2_sel];
    if (ID_rs1_sel == REG_ZERO) ID_rs1_val = '0;
    if (ID_rs2_sel == REG_ZERO) ID_rs2_val = '0;
  end
`endif

  // a full counter cannot take another issue
  assign sat = ID_issue_en && ID_issue_rd != REG_ZERO &&
               cnt[ID_issue_rd] == CMAX;

  assign ID_stall = (ID_rs1_used && busy1) ||
                    (ID_rs2_used && busy2) ||
                    sat;

endmodule
